// File: rtl/info_frame_pkg.sv
// Shared types, constants and packing helpers for the runtime InfoFrame source.
// Header and sub layouts match what the packet assembler consumes.
package info_frame_pkg;

    localparam int MAX_PAYLOAD = 27;
    localparam int SUB_BITS    = 224;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUM  = 2'd1,
        PEND = 2'd2
    } frame_state_e;

    function automatic logic [23:0] build_header(input logic [6:0] type_code,
                                                 input logic [7:0] version,
                                                 input logic [4:0] length);
        return {3'b000, length, version, 1'b1, type_code};
    endfunction

    // Byte 0 is the checksum; payload bytes beyond len are forced to zero.
    function automatic logic [SUB_BITS-1:0] pack_sub(input logic [7:0]               csum,
                                                     input logic [MAX_PAYLOAD*8-1:0] payload,
                                                     input logic [4:0]               len);
        logic [MAX_PAYLOAD*8-1:0] masked;
        masked = '0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (5'(i) < len) begin
                masked[i*8 +: 8] = payload[i*8 +: 8];
            end
        end
        return {masked, csum};
    endfunction

endpackage

// File: rtl/info_frame_checksum_accumulator.sv
// Sequential 8-bit checksum accumulator: seeded with the header sum, then adds
// one payload byte per enabled cycle while walking the index from 1 to LENGTH.
module info_frame_checksum_accumulator (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_add,
    input  logic [7:0] i_seed,
    input  logic [7:0] i_byte,
    input  logic [4:0] i_length,
    output logic [7:0] o_acc,
    output logic [4:0] o_idx,
    output logic       o_last,
    output logic       o_done
);

    logic [7:0] r_acc;
    logic [4:0] r_idx;
    logic       r_done;

    // Accumulator, index counter and done flag.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_acc  <= 8'd0;
            r_idx  <= 5'd0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_acc  <= i_seed;
            r_idx  <= 5'd1;
            r_done <= 1'b0;
        end else if (i_add) begin
            r_acc  <= r_acc + i_byte;
            r_idx  <= r_idx + 5'd1;
            r_done <= r_done | (r_idx == i_length);
        end
    end

    assign o_acc  = r_acc;
    assign o_idx  = r_idx;
    assign o_last = (r_idx == i_length);
    assign o_done = r_done;

endmodule

// File: rtl/runtime_info_frame.sv
// Runtime-programmable InfoFrame source: staged payload, snapshot on commit,
// sequential checksum, and an atomic output load gated by swap_allowed.
module runtime_info_frame
    import info_frame_pkg::*;
#(
    parameter logic [6:0] TYPE    = 7'd2,
    parameter logic [7:0] VERSION = 8'd2,
    parameter logic [4:0] LENGTH  = 5'd13
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         commit,
    input  logic         swap_allowed,
    output logic         busy,
    output logic         valid,
    output logic [23:0]  header,
    output logic [223:0] sub
);

    localparam logic [23:0] HDR  = build_header(TYPE, VERSION, LENGTH);
    localparam logic [7:0]  SEED = HDR[7:0] + HDR[15:8] + HDR[23:16];

    frame_state_e                r_state, w_state_next;
    logic [MAX_PAYLOAD*8-1:0]    r_stage, r_work;
    logic                        r_pend, r_busy, r_valid;
    logic [23:0]                 r_header;
    logic [SUB_BITS-1:0]         r_sub;
    logic                        w_start, w_load, w_add;
    logic [7:0]                  w_byte, w_acc, w_csum;
    logic [4:0]                  w_idx;
    logic                        w_last, w_done;

    info_frame_checksum_accumulator u_acc (
        .clk_pixel (clk_pixel),
        .reset     (reset),
        .i_start   (w_start),
        .i_add     (w_add),
        .i_seed    (SEED),
        .i_byte    (w_byte),
        .i_length  (LENGTH),
        .o_acc     (w_acc),
        .o_idx     (w_idx),
        .o_last    (w_last),
        .o_done    (w_done)
    );

    assign w_add  = (r_state == SUM);
    assign w_csum = 8'd0 - w_acc;

    // Next-state logic; a pending or coincident commit restarts straight from PEND.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (commit) begin
                    w_start      = 1'b1;
                    w_state_next = SUM;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SUM: begin
                if (w_last) begin
                    w_state_next = PEND;
                end else begin
                    w_state_next = SUM;
                end
            end
            PEND: begin
                if (swap_allowed && w_done) begin
                    w_load = 1'b1;
                    if (r_pend || commit) begin
                        w_start      = 1'b1;
                        w_state_next = SUM;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else begin
                    w_state_next = PEND;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Payload byte selected by the accumulator's current index.
    always_comb begin
        w_byte = 8'd0;
        for (int i = 0; i < MAX_PAYLOAD; i++) begin
            if (w_idx == 5'(i + 1)) begin
                w_byte = r_work[i*8 +: 8];
            end
        end
    end

    // Staging writes outside 1..LENGTH are dropped; work snapshots pre-write staging.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_stage <= '0;
            r_work  <= '0;
        end else begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
                if (wr_en && (wr_addr == 5'(i + 1)) && (5'(i + 1) <= LENGTH)) begin
                    r_stage[i*8 +: 8] <= wr_data;
                end
            end
            if (w_start) begin
                r_work <= r_stage;
            end
        end
    end

    // State register, pending-commit flag and busy.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            if (w_start) begin
                r_pend <= 1'b0;
            end else if (commit && (r_state != IDLE)) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Output packet registers, updated only on a completed build.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_header <= 24'd0;
            r_sub    <= '0;
            r_valid  <= 1'b0;
        end else if (w_load) begin
            r_header <= HDR;
            r_sub    <= pack_sub(w_csum, r_work, LENGTH);
            r_valid  <= 1'b1;
        end
    end

    assign busy   = r_busy;
    assign valid  = r_valid;
    assign header = r_header;
    assign sub    = r_sub;

endmodule

// File: doc/runtime_info_frame.md
# runtime_info_frame

Runtime-programmable HDMI InfoFrame source. Supports any InfoFrame type, version and length, not only the fixed AVI layout. Payload bytes are written at run time into a staging buffer. A commit snapshots them and computes the checksum sequentially. The finished packet is loaded into the `header`/`sub` output registers only when the downstream packet picker says a swap is safe. The block sits beside the other packet generators and feeds the same packet-assembler `header`/`sub` inputs.

## Interface
- `TYPE`, default 7'd2: InfoFrame type code; header byte 0 = {1'b1, TYPE}.
- `VERSION`, default 8'd2: header byte 1.
- `LENGTH`, default 5'd13: payload length in bytes; legal range 1..27. Header byte 2 = {3'b000, LENGTH}.

Ports:
- `clk_pixel` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: staging write strobe.
- `wr_addr` in 5: payload byte index. 1..LENGTH is valid; any other value makes the write a no-op.
- `wr_data` in 8: payload byte value.
- `commit` in 1: single-cycle request to build a packet from the current staging contents.
- `swap_allowed` in 1: high when the assembler is not reading `header`/`sub`.
- `busy` out 1: a commit is in progress (snapshot taken, outputs not yet updated).
- `valid` out 1: outputs hold a fully built packet.
- `header` out 24: {byte2, byte1, byte0}.
- `sub` out 224: packet bytes 0..27. `sub[i*56 +: 56]` = bytes 7i..7i+6, with byte 7i in the LSBs.

## Operation
- Staging buffer: 27 bytes, written any cycle by `wr_en`.
- Work buffer: snapshot of the staging buffer taken at commit. Staging writes after a commit never affect the in-flight packet.
- States are IDLE, SUM and PEND.
  - IDLE: `commit` copies staging to work, loads the accumulator with (hdr0 + hdr1 + hdr2) mod 256, sets idx = 1 and moves to SUM.
  - SUM: each cycle the accumulator adds work[idx] (8-bit, wrap mod 256) and idx increments. After adding idx = LENGTH, the state moves to PEND.
  - PEND: checksum = (~acc + 1) mod 256. When `swap_allowed` = 1, the block loads `header`, `sub` byte 0 = checksum and bytes 1..LENGTH = work, forces bytes LENGTH+1..27 to 0, sets `valid` = 1 and moves to IDLE. When `swap_allowed` = 0, it stays in PEND with the outputs unchanged.
- Commit during SUM or PEND sets a one-deep pending flag; further commits merge into that flag. On the PEND→IDLE transition with the flag set, the block clears the flag and performs the IDLE commit action in the same cycle, going straight to SUM. The snapshot is taken at that edge.
- Invariant: the sum of all 3 + 1 + LENGTH packet bytes mod 256 = 0 for every loaded packet.

## Timing
- Reset values: `header` = 0, `sub` = 0, `valid` = 0, `busy` = 0. Staging and work buffers = 0, state = IDLE, pending flag = 0.
- Commit sampled at edge E0 → `busy` = 1 from E0.
- SUM occupies edges E1..E_LENGTH.
- Earliest output load is edge E_LENGTH+1, so new `header`/`sub` are visible LENGTH+2 cycles after `commit` is asserted. `busy` falls at that same edge unless a pending commit restarts it.
- Output registers change only at a PEND→IDLE edge; they are glitch-free and atomic.
- `wr_en` and `commit` in the same cycle: the write lands in staging, but the snapshot uses the pre-write value.
- `reset` in any state aborts the build, drops the pending flag and restores all reset values.

## Structure
- Shared package `info_frame_pkg` holds:
  - the state enum (IDLE/SUM/PEND);
  - the MAX_PAYLOAD = 27 constant;
  - a header-build function (type, version, length) → 24 bits;
  - a byte-array-to-`sub` packing function.
- Sub-module `info_frame_checksum_accumulator` holds the 8-bit accumulator, index counter and done flag. It takes a start pulse, header seed, byte input and LENGTH.

## Test plan
- Reset: after reset, `header` = 0, `sub` = 0, `valid` = 0, `busy` = 0.
- Default AVI build: write byte2 = 0x08 and byte4 = 0x04, then commit with `swap_allowed` = 1. Outputs update 15 cycles later with `header` = 0x0D0282, byte0 = 0x63, `valid` = 1.
- Swap hold: hold `swap_allowed` = 0 for 40 cycles after SUM completes. Outputs stay unchanged and `busy` stays 1. Raising `swap_allowed` gives the load on the next edge.
- Snapshot isolation plus pending: commit, then write byte4 = 0x10 and commit again during SUM.
  - First load carries byte4 = 0x04 with checksum 0x63.
  - Second load carries byte4 = 0x10 with checksum 0x57.
- Address bounds: writes to addr 0, 14 and 27 with LENGTH = 13. Output bytes 14..27 remain 0 and the checksum is unaffected.
- Reset mid-SUM: assert `reset` in cycle 5 of SUM. All outputs return to 0 and no load occurs afterwards.
